// File: rtl/lcd_serial_tx.sv
// Avalon-MM slave that serialises one byte (MSB first) plus an RS flag onto the LCD serial pins.
// Optional transfer-done interrupt is built when LCD_SERIAL_IRQ_EN is defined.
module lcd_serial_tx #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        lcd_cs_n,
    output logic        lcd_sck,
    output logic        lcd_sda,
    output logic        lcd_rs
`ifdef LCD_SERIAL_IRQ_EN
    , output logic      irq
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HI, S_LO, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] divl_q, divl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rs_q, rs_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             wr, rd, busy, tick, accept, hold_exit;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign rd           = chipselect & ~read_n;
    assign busy         = (state_q != S_IDLE);
    assign tick         = (cnt_q == divl_q);
    assign accept       = wr && (address == 2'd0) && !busy;
    assign unused_wdata = ^writedata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divl_d    = divl_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rs_d      = rs_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        hold_exit = 1'b0;

        // Phase counter runs 0..latched divider, so H = DIV+1 even at the maximum value
        if (busy) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    shift_d = writedata[7:0];
                    rs_d    = writedata[8];
                    divl_d  = div_q;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                end
            end
            S_SETUP: if (tick) state_d = S_HI;
            S_HI: begin
                if (tick) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LO;
                        bit_d   = bit_q - 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            S_LO: if (tick) state_d = S_HI;
            S_HOLD: begin
                if (tick) begin
                    state_d   = S_IDLE;
                    hold_exit = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr && (address == 2'd2)) div_d = writedata[DIV_W-1:0];

        // Priority: W1C clear, then frame-end set, then accept clear
        if (wr && (address == 2'd1) && writedata[1]) done_d = 1'b0;
        if (hold_exit) done_d = 1'b1;
        if (accept)    done_d = 1'b0;

        if (wr && (address == 2'd1) && writedata[2]) ovr_d = 1'b0;
        if (wr && (address == 2'd0) && busy)         ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            divl_q  <= '0;
            div_q   <= DIV_W'(DIV_DEFAULT);
            bit_q   <= 3'd7;
            shift_q <= 8'd0;
            rs_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divl_q  <= divl_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rs_q    <= rs_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef LCD_SERIAL_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && (address == 2'd3)) irq_en_d = writedata[0];
        irq_d = done_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        readdata = 16'd0;
        if (rd) begin
            case (address)
                2'd1: readdata = {13'd0, ovr_q, done_q, busy};
                2'd2: readdata = 16'(div_q);
`ifdef LCD_SERIAL_IRQ_EN
                2'd3: readdata = {15'd0, irq_en_q};
`endif
                default: readdata = 16'd0;
            endcase
        end
    end

    // Data line is parked low between frames; RS keeps its last frame value
    assign lcd_cs_n = ~busy;
    assign lcd_sck  = (state_q == S_HI);
    assign lcd_sda  = busy & shift_q[7];
    assign lcd_rs   = rs_q;
endmodule

// File: tb/tb_lcd_serial_tx.sv
// Self-checking bench for lcd_serial_tx: register table, spec scenarios and randomized frames
// compared against a phase-arithmetic model of the serial waveform.
module tb_lcd_serial_tx;
    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        lcd_cs_n;
    logic        lcd_sck;
    logic        lcd_sda;
    logic        lcd_rs;
`ifdef LCD_SERIAL_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_div   = 4;

    lcd_serial_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .lcd_cs_n   (lcd_cs_n),
        .lcd_sck    (lcd_sck),
        .lcd_sda    (lcd_sda),
        .lcd_rs     (lcd_rs)
`ifdef LCD_SERIAL_IRQ_EN
        , .irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 16'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0; address = a;
        #1 d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    // One frame: clears overrun, accepts tx, checks every cycle against the phase model.
    // inj_kind: 0 none, 1 TXDATA write (overrun), 2 DIVIDER write; w1c_end: W1C done on the HOLD-exit cycle.
    task automatic do_frame(input logic [8:0] tx, input int inj_kind, input int inj_k,
                            input logic [7:0] inj_div, input bit w1c_end);
        int h;
        int total;
        int p;
        bit bad;
        bit exp_ovr;
        bit skip_status;
        logic exp_sck;
        logic exp_sda;
        logic [15:0] exp_st;
        logic [15:0] rd_v;
        bus_write(2'd1, 16'h0004);
        h = m_div + 1;
        total = 17 * h;
        bad = 1'b0;
        exp_ovr = 1'b0;
        $display("[TB] frame tx=%h div=%0d inj=%0d@%0d w1c_end=%0d", tx, m_div, inj_kind, inj_k, w1c_end);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = 2'd0; writedata = {7'd0, tx};
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            write_n = 1'b1; read_n = 1'b0; address = 2'd1; writedata = 16'd0;
            skip_status = 1'b0;
            if (k == inj_k && inj_kind == 1) begin
                write_n = 1'b0; read_n = 1'b1; address = 2'd0; writedata = 16'($urandom);
                skip_status = 1'b1;
            end else if (k == inj_k && inj_kind == 2) begin
                write_n = 1'b0; read_n = 1'b1; address = 2'd2; writedata = {8'd0, inj_div};
                skip_status = 1'b1;
            end
            if (k == total - 1 && w1c_end) begin
                write_n = 1'b0; address = 2'd1; writedata = 16'h0002;
            end
            #1;
            p = k / h;
            exp_sck = (p % 2 == 1);
            exp_sda = (p < 16) ? tx[7 - p / 2] : lcd_sda;
            exp_st = exp_ovr ? 16'h0005 : 16'h0001;
            if (!bad && (lcd_cs_n !== 1'b0 || lcd_sck !== exp_sck || lcd_sda !== exp_sda ||
                         lcd_rs !== tx[8] || (!skip_status && readdata !== exp_st))) begin
                bad = 1'b1;
                $display("[TB] frame detail k=%0d cs_n=%b sck=%b/%b sda=%b/%b rs=%b/%b status=%h/%h",
                         k, lcd_cs_n, lcd_sck, exp_sck, lcd_sda, exp_sda, lcd_rs, tx[8], readdata, exp_st);
            end
            if (k == inj_k && inj_kind == 1) exp_ovr = 1'b1;
        end
        check("frame_waveform_mismatch", {15'd0, bad}, 16'd0);
        @(negedge clk);
        write_n = 1'b1; read_n = 1'b0; address = 2'd1; writedata = 16'd0;
        #1;
        check("idle_pins", {12'd0, lcd_cs_n, lcd_sck, lcd_sda, lcd_rs}, {12'd0, 1'b1, 1'b0, 1'b0, tx[8]});
        check("idle_status", readdata, exp_ovr ? 16'h0006 : 16'h0002);
        chipselect = 1'b0; read_n = 1'b1;
        if (inj_kind == 2) m_div = int'(inj_div);
        rd_v = 16'd0;
    endtask

    initial begin
        logic [15:0] rv;
        logic [15:0] ctrl_exp;
        int d;
        int total;
`ifdef LCD_SERIAL_IRQ_EN
        ctrl_exp = 16'h0001;
`else
        ctrl_exp = 16'h0000;
`endif
        vecs[0]  = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h0004};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 16'hA5A5, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h00A5};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 2'd3, 16'hFFFF, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 16'h0000, ctrl_exp};
        vecs[9]  = '{1'b1, 1'b0, 2'd3, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 2'd1, 16'hFFFF, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h0000};
        vecs[14] = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000};

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 2'd0; writedata = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_pins", {12'd0, lcd_cs_n, lcd_sck, lcd_sda, lcd_rs}, 16'h0008);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
                $display("[TB] wr addr=%0d data=%h", vecs[i].addr, vecs[i].data);
            end else begin
                @(negedge clk);
                chipselect = 1'b1; write_n = 1'b1; read_n = ~vecs[i].rd; address = vecs[i].addr;
                #1 check($sformatf("vec%0d_read_addr%0d", i, vecs[i].addr), readdata, vecs[i].exp);
                chipselect = 1'b0; read_n = 1'b1;
            end
        end
        m_div = 0;

        do_frame(9'h1A5, 0, -1, 8'd0, 1'b0);
        do_frame(9'h1A5, 1, 5, 8'd0, 1'b0);
        bus_write(2'd1, 16'h0006);
        bus_read(2'd1, rv);
        check("status_after_w1c", rv, 16'h0000);

        bus_write(2'd2, 16'd3);
        m_div = 3;
        do_frame(9'h0FF, 0, -1, 8'd0, 1'b0);
        do_frame(9'h13C, 0, -1, 8'd0, 1'b1);
        do_frame(9'h05A, 2, 7, 8'd1, 1'b0);
        do_frame(9'h1C3, 0, -1, 8'd0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            d = $urandom_range(0, 4);
            bus_write(2'd2, 16'(d));
            m_div = d;
            total = 17 * (d + 1);
            do_frame(9'($urandom_range(0, 511)), $urandom_range(0, 2), $urandom_range(0, total - 2),
                     8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a frame
        bus_write(2'd2, 16'd1);
        m_div = 1;
        bus_write(2'd0, 16'h01C3);
        repeat (10) @(negedge clk);
        #1 check("pre_reset_sck", {15'd0, lcd_sck}, 16'h0001);
        reset_n = 1'b0;
        #1 check("midframe_reset_pins", {12'd0, lcd_cs_n, lcd_sck, lcd_sda, lcd_rs}, 16'h0008);
        @(negedge clk);
        reset_n = 1'b1;
        m_div = 4;
        bus_read(2'd1, rv);
        check("status_after_reset", rv, 16'h0000);
        bus_read(2'd2, rv);
        check("divider_after_reset", rv, 16'h0004);

`ifdef LCD_SERIAL_IRQ_EN
        bus_write(2'd3, 16'h0001);
        do_frame(9'h0E7, 0, -1, 8'd0, 1'b0);
        check("irq_on_done_cycle", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        #1 check("irq_after_done", {15'd0, irq}, 16'h0001);
        bus_write(2'd1, 16'h0002);
        @(negedge clk);
        #1 check("irq_after_w1c", {15'd0, irq}, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
